// File: rtl/wb_queue_pkg.sv
// Shared types and sizing for the writeback queue and its lookup matcher.
package wb_queue_pkg;

    localparam int WIDTH     = 16;
    localparam int REG_SEL_W = 3;
    localparam int DEPTH     = 4;
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    // One pending writeback: destination register and its value.
    typedef struct packed {
        logic [REG_SEL_W-1:0] regsel;
        logic [WIDTH-1:0]     data;
    } wbq_entry_t;

endpackage

// File: rtl/wb_queue_lookup.sv
// Youngest-first match of a register select against the pending queue entries.
module wb_queue_lookup
    import wb_queue_pkg::*;
(
    input  wbq_entry_t [DEPTH-1:0] entries_i,
    input  logic [PTR_W-1:0]       head_i,
    input  logic [CNT_W-1:0]       count_i,
    input  logic [REG_SEL_W-1:0]   sel_i,
    output logic                   hit_o,
    output logic [WIDTH-1:0]       data_o
);

    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last (youngest) valid match wins.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = head_i;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_i + PTR_W'(i);
            if ((CNT_W'(i) < count_i) && (entries_i[idx].regsel == sel_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback buffer feeding the register file write port, with two
// bypass lookup ports returning the youngest pending value for a register.
module wb_queue
    import wb_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_SEL_W-1:0] in_reg,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 hold,
    output logic [REG_SEL_W-1:0] writeRegSel,
    output logic [WIDTH-1:0]     writeData,
    output logic                 writeEn,
    input  logic [REG_SEL_W-1:0] look1Sel,
    input  logic [REG_SEL_W-1:0] look2Sel,
    output logic                 look1Hit,
    output logic                 look2Hit,
    output logic [WIDTH-1:0]     look1Data,
    output logic [WIDTH-1:0]     look2Data,
    output logic [CNT_W-1:0]     count,
    output logic                 err
);

    wbq_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   push, pop, ovf, unf;

    // Handshake and next-state pointers; a full queue that retires can still accept.
    always_comb begin
        pop      = (count_q != '0) && !hold;
        in_ready = (count_q != CNT_W'(DEPTH)) || pop;
        push     = in_valid && in_ready;
        head_d   = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d   = push ? tail_q + PTR_W'(1) : tail_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        ovf      = push && !pop && (count_q == CNT_W'(DEPTH));
        unf      = pop && (count_q == '0);
    end

    // Register file write port straight from the head entry; zeroed when idle.
    always_comb begin
        writeEn     = pop;
        writeRegSel = pop ? mem_q[head_q].regsel : '0;
        writeData   = pop ? mem_q[head_q].data   : '0;
        count       = count_q;
    end

    // X on control inputs (or on in_reg while it matters) and impossible
    // occupancy transitions are both reported as errors.
    always_comb begin
        err = $isunknown({clk, rst, in_valid, hold}) ||
              (in_valid && $isunknown(in_reg)) || ovf || unf;
    end

    // Pointer and occupancy state; reset discards all pending entries.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only meaningful between head and head+count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{regsel: in_reg, data: in_data};
        end
    end

    wb_queue_lookup u_look1 (
        .entries_i (mem_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .sel_i     (look1Sel),
        .hit_o     (look1Hit),
        .data_o    (look1Data)
    );

    wb_queue_lookup u_look2 (
        .entries_i (mem_q),
        .head_i    (head_q),
        .count_i   (count_q),
        .sel_i     (look2Sel),
        .hit_o     (look2Hit),
        .data_o    (look2Data)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue with a behavioural register file on the write port.
module tb_wb_queue;
    import wb_queue_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [REG_SEL_W-1:0] in_reg = '0;
    logic [WIDTH-1:0]     in_data = '0;
    logic                 hold = 1'b0;
    logic [REG_SEL_W-1:0] writeRegSel;
    logic [WIDTH-1:0]     writeData;
    logic                 writeEn;
    logic [REG_SEL_W-1:0] look1Sel = '0;
    logic [REG_SEL_W-1:0] look2Sel = '0;
    logic                 look1Hit, look2Hit;
    logic [WIDTH-1:0]     look1Data, look2Data;
    logic [CNT_W-1:0]     count;
    logic                 err;

    int n_chk  = 0;
    int n_pass = 0;

    logic [WIDTH-1:0] rf [8];
    logic [18:0]      wlog [$];

    logic [2:0]  exp_r [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [15:0] exp_d [5] = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0055};

    always #5 clk = ~clk;

    wb_queue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg(in_reg), .in_data(in_data), .hold(hold),
        .writeRegSel(writeRegSel), .writeData(writeData), .writeEn(writeEn),
        .look1Sel(look1Sel), .look2Sel(look2Sel),
        .look1Hit(look1Hit), .look2Hit(look2Hit),
        .look1Data(look1Data), .look2Data(look2Data),
        .count(count), .err(err)
    );

    // Register file model: captures the write port at each rising edge.
    always @(posedge clk) begin
        if (writeEn === 1'b1) begin
            rf[writeRegSel] <= writeData;
            wlog.push_back({writeRegSel, writeData});
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        for (int i = 0; i < 8; i++) rf[i] = '0;

        // Reset
        tick(); tick();
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_wen", 32'(writeEn), 0);
        chk("rst_wsel", 32'(writeRegSel), 0);
        chk("rst_wdata", 32'(writeData), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_err", 32'(err), 0);
        chk("rst_l1hit", 32'(look1Hit), 0);
        chk("rst_l1data", 32'(look1Data), 0);
        rst = 1'b1;
        tick();

        // Single push into an empty queue
        in_valid = 1; in_reg = 3; in_data = 16'hBEEF;
        #1 chk("t1_ready", 32'(in_ready), 1);
        tick();
        in_valid = 0;
        #1;
        chk("t1_wen", 32'(writeEn), 1);
        chk("t1_wsel", 32'(writeRegSel), 3);
        chk("t1_wdata", 32'(writeData), 32'hBEEF);
        chk("t1_count", 32'(count), 1);
        tick();
        #1;
        chk("t1_rf3", 32'(rf[3]), 32'hBEEF);
        chk("t1_count0", 32'(count), 0);
        chk("t1_wen0", 32'(writeEn), 0);

        // Fill under hold, 5th blocked, then drain in order
        hold = 1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1; in_reg = 3'(i); in_data = 16'(i);
            tick();
        end
        in_valid = 0;
        #1;
        chk("t2_count4", 32'(count), 4);
        chk("t2_ready0", 32'(in_ready), 0);
        chk("t2_wen_hold", 32'(writeEn), 0);
        in_valid = 1; in_reg = 7; in_data = 16'h0055;
        #1 chk("t2_5th_ready", 32'(in_ready), 0);
        tick();
        #1 chk("t2_5th_rej", 32'(count), 4);
        hold = 0;
        #1;
        chk("t2_ready_pop", 32'(in_ready), 1);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t2_wen%0d", k), 32'(writeEn), 1);
            chk($sformatf("t2_wsel%0d", k), 32'(writeRegSel), 32'(exp_r[k]));
            chk($sformatf("t2_wdata%0d", k), 32'(writeData), 32'(exp_d[k]));
            if (k == 0) begin
                tick();
                in_valid = 0;
                #1 chk("t2_count_swap", 32'(count), 4);
            end else begin
                tick();
            end
        end
        #1;
        chk("t2_count_end", 32'(count), 0);
        chk("t2_rf7", 32'(rf[7]), 32'h0055);
        chk("t2_rf4", 32'(rf[4]), 32'h0004);

        // Youngest-wins lookup
        hold = 1;
        in_valid = 1; in_reg = 5; in_data = 16'h1111; tick();
        in_data = 16'h2222; tick();
        in_valid = 0; look1Sel = 5;
        #1;
        chk("t3_l1hit", 32'(look1Hit), 1);
        chk("t3_l1data", 32'(look1Data), 32'h2222);
        chk("t3_count", 32'(count), 2);
        hold = 0;
        tick(); tick();
        #1;
        chk("t3_rf5", 32'(rf[5]), 32'h2222);
        chk("t3_l1hit0", 32'(look1Hit), 0);
        chk("t3_l1data0", 32'(look1Data), 0);

        // Miss, then visibility window of a pushed entry
        look2Sel = 6;
        #1;
        chk("t4_l2hit0", 32'(look2Hit), 0);
        chk("t4_l2data0", 32'(look2Data), 0);
        in_valid = 1; in_reg = 6; in_data = 16'h00AA;
        #1 chk("t4_l2_notyet", 32'(look2Hit), 0);
        tick();
        in_valid = 0;
        #1;
        chk("t4_l2hit", 32'(look2Hit), 1);
        chk("t4_l2data", 32'(look2Data), 32'h00AA);
        tick();
        #1;
        chk("t4_l2hit_ret", 32'(look2Hit), 0);
        chk("t4_rf6", 32'(rf[6]), 32'h00AA);

        // Reset drops pending entries without writing them
        hold = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_reg = 3'(i); in_data = 16'hD000 + 16'(i);
            tick();
        end
        in_valid = 0;
        #1 chk("t5_count3", 32'(count), 3);
        base = wlog.size();
        rst = 0;
        tick();
        #1;
        chk("t5_count0", 32'(count), 0);
        chk("t5_wen0", 32'(writeEn), 0);
        chk("t5_ready1", 32'(in_ready), 1);
        rst = 1; hold = 0;
        tick(); tick();
        chk("t5_nowrite", 32'(wlog.size()), 32'(base));
        chk("t5_rf0", 32'(rf[0]), 0);

        // Back-to-back streaming across the pointer wrap
        base = wlog.size();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1; in_reg = 3'(i); in_data = 16'h0100 + 16'(i);
            #1;
            chk($sformatf("t6_err%0d", i), 32'(err), 0);
            chk($sformatf("t6_cnt%0d", i), 32'(count <= 1), 1);
            tick();
        end
        in_valid = 0;
        tick();
        #1;
        chk("t6_nwr", 32'(wlog.size() - base), 10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < wlog.size())
                chk($sformatf("t6_wr%0d", i), 32'(wlog[base + i]),
                    32'({3'(i), 16'h0100 + 16'(i)}));
            else
                chk($sformatf("t6_wr%0d_missing", i), 32'(wlog.size()), 32'(base + i + 1));
        end
        chk("t6_count_end", 32'(count), 0);
        chk("t6_err_end", 32'(err), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
